// File: rtl/round_controller_if.sv
// ---------------------------------------------------------------------------
// round_controller_if
// Groups the round controller's frame/button/handshake inputs and its game
// status outputs into one bundle.
//   master : the round controller (drives step_en, clear_req, state, scores...)
//   slave  : the surrounding datapath / VGA timing (drives frame_start,
//            start_n, clear_ack, crash verdicts)
// ---------------------------------------------------------------------------
interface round_controller_if #(
    parameter int unsigned SCORE_W = 4
);
    logic               frame_start;
    logic               start_n;
    logic               clear_ack;
    logic               crash_valid;
    logic               crash_p1;
    logic               crash_p2;
    logic               step_en;
    logic               clear_req;
    logic [2:0]         state;
    logic [1:0]         countdown;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic [1:0]         winner;
    logic               game_over;

    modport master (
        input  frame_start, start_n, clear_ack, crash_valid, crash_p1, crash_p2,
        output step_en, clear_req, state, countdown, score_p1, score_p2, winner, game_over
    );

    modport slave (
        output frame_start, start_n, clear_ack, crash_valid, crash_p1, crash_p2,
        input  step_en, clear_req, state, countdown, score_p1, score_p2, winner, game_over
    );
endinterface

// File: rtl/round_controller.sv
// ---------------------------------------------------------------------------
// round_controller
// Sequences the two-player light-cycle game: idle, arena clear, 3-2-1
// countdown, run, crash hold and match end. Issues frame-synchronous step
// pulses to the player movers, requests arena reinit, and keeps scores.
// Ports:
//   CLOCK_50 : system clock
//   reset    : synchronous, active-high
//   bus      : round_controller_if.master
//              in : frame_start, start_n (async, active-low), clear_ack,
//                   crash_valid, crash_p1, crash_p2
//              out: step_en, clear_req, state, countdown, score_p1/p2,
//                   winner, game_over (all registered)
// ---------------------------------------------------------------------------
module round_controller #(
    parameter int unsigned STEP_FRAMES  = 6,
    parameter int unsigned COUNT_FRAMES = 60,
    parameter int unsigned HOLD_FRAMES  = 120,
    parameter int unsigned WIN_SCORE    = 5,
    parameter int unsigned SCORE_W      = 4
) (
    input logic                CLOCK_50,
    input logic                reset,
    round_controller_if.master bus
);

    localparam int unsigned MAX_A      = (STEP_FRAMES > COUNT_FRAMES) ? STEP_FRAMES : COUNT_FRAMES;
    localparam int unsigned MAX_FRAMES = (MAX_A > HOLD_FRAMES) ? MAX_A : HOLD_FRAMES;
    localparam int unsigned CNT_W      = (MAX_FRAMES < 2) ? 1 : $clog2(MAX_FRAMES);

    localparam logic [CNT_W-1:0]   STEP_LAST  = CNT_W'(STEP_FRAMES - 1);
    localparam logic [CNT_W-1:0]   COUNT_LAST = CNT_W'(COUNT_FRAMES - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_COUNTDOWN = 3'd2,
        S_RUN       = 3'd3,
        S_CRASH     = 3'd4,
        S_MATCH_END = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [1:0]         countdown_q, countdown_d;
    logic [SCORE_W-1:0] score_p1_q, score_p1_d;
    logic [SCORE_W-1:0] score_p2_q, score_p2_d;
    logic [1:0]         winner_q, winner_d;
    logic               clear_req_q, clear_req_d;
    logic               step_en_q, step_en_d;
    logic               game_over_q, game_over_d;
    logic [2:0]         start_sync_q, start_sync_d;
    logic               press;

    // [0],[1] synchronise the async button, [2] holds the previous synced value
    assign start_sync_d = {start_sync_q[1:0], bus.start_n};
    assign press        = start_sync_q[2] & ~start_sync_q[1];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= S_IDLE;
            frame_cnt_q  <= '0;
            countdown_q  <= '0;
            score_p1_q   <= '0;
            score_p2_q   <= '0;
            winner_q     <= '0;
            clear_req_q  <= 1'b0;
            step_en_q    <= 1'b0;
            game_over_q  <= 1'b0;
            start_sync_q <= '1;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            countdown_q  <= countdown_d;
            score_p1_q   <= score_p1_d;
            score_p2_q   <= score_p2_d;
            winner_q     <= winner_d;
            clear_req_q  <= clear_req_d;
            step_en_q    <= step_en_d;
            game_over_q  <= game_over_d;
            start_sync_q <= start_sync_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        countdown_d = countdown_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        winner_d    = winner_q;
        clear_req_d = clear_req_q;
        step_en_d   = 1'b0;
        game_over_d = game_over_q;

        unique case (state_q)
            S_IDLE, S_MATCH_END: begin
                if (press) begin
                    state_d     = S_CLEAR;
                    frame_cnt_d = '0;
                    score_p1_d  = '0;
                    score_p2_d  = '0;
                    winner_d    = '0;
                    clear_req_d = 1'b1;
                    game_over_d = 1'b0;
                end
            end

            S_CLEAR: begin
                if (bus.clear_ack) begin
                    state_d     = S_COUNTDOWN;
                    frame_cnt_d = '0;
                    clear_req_d = 1'b0;
                    countdown_d = 2'd3;
                end
            end

            S_COUNTDOWN: begin
                if (bus.frame_start) begin
                    if (frame_cnt_q == COUNT_LAST) begin
                        frame_cnt_d = '0;
                        if (countdown_q == 2'd1) begin
                            state_d     = S_RUN;
                            countdown_d = '0;
                            winner_d    = '0;
                        end else begin
                            countdown_d = countdown_q - 2'd1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_ONE;
                    end
                end
            end

            S_RUN: begin
                // A real crash pre-empts a coincident step frame
                if (bus.crash_valid && (bus.crash_p1 || bus.crash_p2)) begin
                    state_d     = S_CRASH;
                    frame_cnt_d = '0;
                    if (bus.crash_p1 && bus.crash_p2) begin
                        winner_d = 2'd3;
                    end else if (bus.crash_p1) begin
                        winner_d = 2'd2;
                        if (score_p2_q < WIN_S) score_p2_d = score_p2_q + SCORE_ONE;
                    end else begin
                        winner_d = 2'd1;
                        if (score_p1_q < WIN_S) score_p1_d = score_p1_q + SCORE_ONE;
                    end
                end else if (bus.frame_start) begin
                    if (frame_cnt_q == STEP_LAST) begin
                        frame_cnt_d = '0;
                        step_en_d   = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_ONE;
                    end
                end
            end

            S_CRASH: begin
                if (bus.frame_start) begin
                    if (frame_cnt_q == HOLD_LAST) begin
                        frame_cnt_d = '0;
                        if (score_p1_q == WIN_S || score_p2_q == WIN_S) begin
                            state_d     = S_MATCH_END;
                            game_over_d = 1'b1;
                        end else begin
                            state_d     = S_CLEAR;
                            clear_req_d = 1'b1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_ONE;
                    end
                end
            end

            default: begin
                state_d     = S_IDLE;
                frame_cnt_d = '0;
            end
        endcase
    end

    assign bus.state     = state_q;
    assign bus.step_en   = step_en_q;
    assign bus.clear_req = clear_req_q;
    assign bus.countdown = countdown_q;
    assign bus.score_p1  = score_p1_q;
    assign bus.score_p2  = score_p2_q;
    assign bus.winner    = winner_q;
    assign bus.game_over = game_over_q;

endmodule
